// File: rtl/inv_round_key_feeder_if.sv
// Round-key stream between the inverse key feeder and the inverse-cipher datapath.
// The master drives key/index/last with valid, and the slave answers with ready.
interface inv_round_key_feeder_if #(
   parameter int KW = 128
);
   logic          rk_valid;
   logic          rk_ready;
   logic [KW-1:0] round_key;
   logic [3:0]    round_idx;
   logic          rk_last;

   modport master (output rk_valid, round_key, round_idx, rk_last, input rk_ready);
   modport slave  (input rk_valid, round_key, round_idx, rk_last, output rk_ready);
endinterface

// File: rtl/inv_round_key_feeder.sv
// Latches the cipher key and the expanded round keys into a local bank, then
// replays the bank from round 10 down to round 0 over a valid/ready stream.
module inv_round_key_feeder #(
   parameter int KW = 128,
   parameter int NR = 10
) (
   input  logic          HCLK,
   input  logic          n_rst,
   input  logic          keys_ready,
   input  logic [KW-1:0] keyword,
   input  logic [KW-1:0] subkey0,
   input  logic [KW-1:0] subkey1,
   input  logic [KW-1:0] subkey2,
   input  logic [KW-1:0] subkey3,
   input  logic [KW-1:0] subkey4,
   input  logic [KW-1:0] subkey5,
   input  logic [KW-1:0] subkey6,
   input  logic [KW-1:0] subkey7,
   input  logic [KW-1:0] subkey8,
   input  logic [KW-1:0] subkey9,
   input  logic          start,
   input  logic          abort,
   inv_round_key_feeder_if.master rk,
   output logic          busy,
   output logic          done,
   output logic          start_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [3:0] TOP = 4'(NR);

   state_t                 state, state_nxt;
   logic [NR-1:0][KW-1:0]  sk;
   logic [NR:0][KW-1:0]    bank;
   logic [3:0]             idx;
   logic                   accept, launch;

   assign sk = {subkey9, subkey8, subkey7, subkey6, subkey5,
                subkey4, subkey3, subkey2, subkey1, subkey0};

   assign accept = rk.rk_valid & rk.rk_ready;
   assign launch = (state == IDLE) & start & keys_ready & ~abort;

   always_ff @(posedge HCLK or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // abort outranks acceptance, so an aborted final beat never reaches DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = ISSUE;
         ISSUE:   if (abort) state_nxt = IDLE;
                  else if (accept && idx == 4'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is registered: status comes from the next state, and the
   // key register is preloaded with the next bank entry as each beat is taken.
   always_ff @(posedge HCLK or negedge n_rst) begin
      if (!n_rst) begin
         bank         <= '0;
         idx          <= '0;
         rk.rk_valid  <= 1'b0;
         rk.round_key <= '0;
         rk.round_idx <= '0;
         rk.rk_last   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         start_err    <= 1'b0;
      end else begin
         rk.rk_valid <= (state_nxt == ISSUE);
         busy        <= (state_nxt != IDLE);
         done        <= (state_nxt == DONE);
         start_err   <= (state == IDLE) & start & ~keys_ready & ~abort;
         if (launch) begin
            bank         <= {sk, keyword};
            idx          <= TOP;
            rk.round_key <= sk[NR-1];
            rk.round_idx <= TOP;
            rk.rk_last   <= 1'b0;
         end else if (state == ISSUE && accept && !abort && idx != 4'd0) begin
            idx          <= idx - 4'd1;
            rk.round_key <= bank[idx - 4'd1];
            rk.round_idx <= idx - 4'd1;
            rk.rk_last   <= (idx == 4'd1);
         end
      end
   end
endmodule

// File: tb/tb_inv_round_key_feeder.sv
// Bench for inv_round_key_feeder: AES-128 key expansion model feeding the
// bank, random/back-pressured replays compared against the expected key order.
module tb_inv_round_key_feeder;
   logic         HCLK = 1'b0;
   logic         n_rst = 1'b0;
   logic         keys_ready = 1'b0, start = 1'b0, abort = 1'b0;
   logic [127:0] keyword = '0;
   logic [127:0] sk [0:9];
   logic         busy, done, start_err;

   inv_round_key_feeder_if #(.KW(128)) rk_bus ();

   always #5 HCLK = ~HCLK;

   inv_round_key_feeder #(.KW(128), .NR(10)) dut (
      .HCLK(HCLK), .n_rst(n_rst), .keys_ready(keys_ready), .keyword(keyword),
      .subkey0(sk[0]), .subkey1(sk[1]), .subkey2(sk[2]), .subkey3(sk[3]), .subkey4(sk[4]),
      .subkey5(sk[5]), .subkey6(sk[6]), .subkey7(sk[7]), .subkey8(sk[8]), .subkey9(sk[9]),
      .start(start), .abort(abort), .rk(rk_bus), .busy(busy), .done(done), .start_err(start_err)
   );

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   int errors = 0, checks = 0;
   logic [127:0] mk [0:10];          // model round keys, mk[r] = AES round r key
   int           n_beats, done_cyc, hold_bad, serr_seen;
   logic [3:0]   b_idx  [0:15];
   logic [127:0] b_key  [0:15];
   logic         b_last [0:15];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic load_inputs(input logic [127:0] k);
      expand(k);
      keyword = mk[0];
      for (int i = 0; i < 10; i++) sk[i] = mk[i+1];
      keys_ready = 1'b1;
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // rmode 0: ready always high, 1: ready 1-0-1-0, 2: random ready.
   // corrupt: scrambles the key inputs and pokes start while the sequence runs.
   task automatic play(input int rmode, input bit corrupt);
      bit pv, pr, rdy;
      logic [3:0] pidx; logic [127:0] pkey; logic plast;
      n_beats = 0; done_cyc = -1; hold_bad = 0; serr_seen = 0; pv = 0; pr = 0;
      pidx = '0; pkey = '0; plast = 1'b0;
      for (int i = 0; i < 16; i++) begin b_idx[i] = 'x; b_key[i] = 'x; b_last[i] = 'x; end
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (corrupt && cyc == 3) begin
            keys_ready = 1'b0; keyword = '0;
            for (int i = 0; i < 10; i++) sk[i] = '0;
         end
         start = (corrupt && cyc == 5) || (rmode == 2 && cyc == 4);
         if (start_err) serr_seen++;
         if (pv && !pr && (rk_bus.rk_valid !== 1'b1 || rk_bus.round_idx !== pidx ||
                           rk_bus.round_key !== pkey || rk_bus.rk_last !== plast)) hold_bad++;
         if (done === 1'b1) begin done_cyc = cyc; break; end
         rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
         rk_bus.rk_ready = rdy;
         if (rk_bus.rk_valid === 1'b1 && rdy && n_beats < 16) begin
            b_idx[n_beats] = rk_bus.round_idx; b_key[n_beats] = rk_bus.round_key;
            b_last[n_beats] = rk_bus.rk_last; n_beats++;
         end
         pv = (rk_bus.rk_valid === 1'b1); pr = rdy;
         pidx = rk_bus.round_idx; pkey = rk_bus.round_key; plast = rk_bus.rk_last;
         @(negedge HCLK);
      end
      start = 1'b0; rk_bus.rk_ready = 1'b0;
      @(negedge HCLK);
   endtask

   task automatic test_reset();
      @(negedge HCLK);
      checks++; if ({rk_bus.rk_valid, rk_bus.round_key, rk_bus.round_idx, rk_bus.rk_last, busy, done, start_err} !== '0) begin
         errors++; $display("FAIL reset_outputs: got v=%b key=%h idx=%0d busy=%b done=%b err=%b want all 0",
            rk_bus.rk_valid, rk_bus.round_key, rk_bus.round_idx, busy, done, start_err); end
      n_rst = 1'b1;
      @(negedge HCLK);
      checks++; if ({rk_bus.rk_valid, busy, done, start_err} !== 4'b0) begin
         errors++; $display("FAIL reset_release: got v=%b busy=%b done=%b err=%b want 0", rk_bus.rk_valid, busy, done, start_err); end
   endtask

   task automatic test_fips();
      load_inputs(FIPS_KEY);
      play(0, 0);
      checks++; if (n_beats !== 11) begin errors++; $display("FAIL fips_beats: got %0d want 11", n_beats); end
      checks++; if (b_idx[0] !== 4'd10) begin errors++; $display("FAIL fips_idx0: got %0d want 10", b_idx[0]); end
      checks++; if (b_key[0] !== FIPS_RK10) begin errors++; $display("FAIL fips_key0: got %h want %h", b_key[0], FIPS_RK10); end
      checks++; if (b_last[0] !== 1'b0) begin errors++; $display("FAIL fips_last0: got %b want 0", b_last[0]); end
      checks++; if (b_key[10] !== FIPS_KEY) begin errors++; $display("FAIL fips_key10: got %h want %h", b_key[10], FIPS_KEY); end
      checks++; if (b_last[10] !== 1'b1) begin errors++; $display("FAIL fips_last10: got %b want 1", b_last[10]); end
      checks++; if (done_cyc !== 12) begin errors++; $display("FAIL fips_done_cycle: got %0d want 12", done_cyc); end
      for (int r = 0; r < 11; r++) begin
         checks++; if (b_idx[r] !== 4'(10 - r) || b_key[r] !== mk[10 - r]) begin
            errors++; $display("FAIL fips_beat%0d: got idx=%0d key=%h want idx=%0d key=%h", r, b_idx[r], b_key[r], 10 - r, mk[10 - r]); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fips_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_backpressure();
      load_inputs(FIPS_KEY);
      play(1, 0);
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_bad); end
      checks++; if (n_beats !== 11) begin errors++; $display("FAIL bp_beats: got %0d want 11", n_beats); end
      checks++; if (done_cyc !== 22) begin errors++; $display("FAIL bp_done_cycle: got %0d want 22", done_cyc); end
      for (int r = 0; r < 11; r++) begin
         checks++; if (b_idx[r] !== 4'(10 - r) || b_key[r] !== mk[10 - r] || b_last[r] !== (r == 10)) begin
            errors++; $display("FAIL bp_beat%0d: got idx=%0d key=%h last=%b want idx=%0d key=%h", r, b_idx[r], b_key[r], b_last[r], 10 - r, mk[10 - r]); end
      end
   endtask

   task automatic test_start_err();
      keys_ready = 1'b0; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      checks++; if ({start_err, busy, rk_bus.rk_valid} !== 3'b100) begin
         errors++; $display("FAIL start_err_pulse: got err=%b busy=%b v=%b want 1 0 0", start_err, busy, rk_bus.rk_valid); end
      @(negedge HCLK);
      checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL start_err_width: got %b want 0", start_err); end
      load_inputs(rand_key());
      abort = 1'b1; start = 1'b1;
      @(negedge HCLK);
      abort = 1'b0; start = 1'b0;
      checks++; if ({busy, rk_bus.rk_valid, start_err} !== 3'b000) begin
         errors++; $display("FAIL idle_abort_wins: got busy=%b v=%b err=%b want 0 0 0", busy, rk_bus.rk_valid, start_err); end
   endtask

   task automatic test_freeze();
      load_inputs(rand_key());
      play(2, 1);
      checks++; if (n_beats !== 11) begin errors++; $display("FAIL freeze_beats: got %0d want 11", n_beats); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL freeze_hold: got %0d want 0", hold_bad); end
      checks++; if (serr_seen !== 0) begin errors++; $display("FAIL freeze_start_err: got %0d pulses want 0", serr_seen); end
      checks++; if (done_cyc < 12) begin errors++; $display("FAIL freeze_done: got cycle %0d want >=12", done_cyc); end
      for (int r = 0; r < 11; r++) begin
         checks++; if (b_idx[r] !== 4'(10 - r) || b_key[r] !== mk[10 - r]) begin
            errors++; $display("FAIL freeze_beat%0d: got idx=%0d key=%h want idx=%0d key=%h", r, b_idx[r], b_key[r], 10 - r, mk[10 - r]); end
      end
   endtask

   task automatic run_to_idx(input logic [3:0] target, input string name);
      int n;
      n = 0;
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0; rk_bus.rk_ready = 1'b1;
      while (!(rk_bus.rk_valid === 1'b1 && rk_bus.round_idx === target) && n < 50) begin
         @(negedge HCLK); n++;
      end
      checks++; if (rk_bus.rk_valid !== 1'b1 || rk_bus.round_idx !== target) begin
         errors++; $display("FAIL %s_reach: got v=%b idx=%0d want v=1 idx=%0d", name, rk_bus.rk_valid, rk_bus.round_idx, target); end
   endtask

   task automatic test_abort();
      bit dseen;
      load_inputs(rand_key());
      run_to_idx(4'd4, "abort");
      abort = 1'b1;
      @(negedge HCLK);
      abort = 1'b0; rk_bus.rk_ready = 1'b0;
      checks++; if ({rk_bus.rk_valid, busy, done} !== 3'b000) begin
         errors++; $display("FAIL abort_stop: got v=%b busy=%b done=%b want 0 0 0", rk_bus.rk_valid, busy, done); end
      dseen = 0;
      repeat (3) begin @(negedge HCLK); if (done !== 1'b0) dseen = 1; end
      checks++; if (dseen) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
      load_inputs(rand_key());
      play(0, 0);
      checks++; if (b_idx[0] !== 4'd10 || b_key[0] !== mk[10]) begin
         errors++; $display("FAIL abort_restart: got idx=%0d key=%h want idx=10 key=%h", b_idx[0], b_key[0], mk[10]); end
      checks++; if (n_beats !== 11 || done_cyc !== 12) begin
         errors++; $display("FAIL abort_restart_len: got beats=%0d done=%0d want 11 12", n_beats, done_cyc); end
   endtask

   task automatic test_reset_mid();
      bit dseen;
      load_inputs(rand_key());
      run_to_idx(4'd6, "rstmid");
      #2 n_rst = 1'b0;
      #1;
      checks++; if ({rk_bus.rk_valid, rk_bus.round_key, rk_bus.round_idx, rk_bus.rk_last, busy, done, start_err} !== '0) begin
         errors++; $display("FAIL rstmid_async: got v=%b key=%h idx=%0d busy=%b done=%b want all 0",
            rk_bus.rk_valid, rk_bus.round_key, rk_bus.round_idx, busy, done); end
      @(negedge HCLK);
      n_rst = 1'b1; rk_bus.rk_ready = 1'b0;
      dseen = 0;
      repeat (3) begin @(negedge HCLK); if (done !== 1'b0) dseen = 1; end
      checks++; if ({busy, rk_bus.rk_valid} !== 2'b00 || dseen) begin
         errors++; $display("FAIL rstmid_idle: got busy=%b v=%b done_seen=%b want 0 0 0", busy, rk_bus.rk_valid, dseen); end
   endtask

   initial begin
      rk_bus.rk_ready = 1'b0;
      for (int i = 0; i < 10; i++) sk[i] = '0;
      test_reset();
      test_fips();
      test_backpressure();
      test_start_err();
      test_freeze();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
